// File: rtl/imem_loader.sv
// Packs a big-endian byte stream into 32-bit words and writes them to
// instruction SRAM from BASE_ADDR upward, holding the CPU off while busy.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  output logic             in_ready,
  output logic             mem_cs,
  output logic             mem_oe,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_din,
  output logic             cpu_hold,
  output logic             done,
  output logic [CNT_W-1:0] words_done,
  output logic [31:0]      checksum
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSEMBLE = 2'd1,
    WRITE    = 2'd2,
    DONE_ST  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] num_cap;
  logic [1:0]       byte_cnt;
  logic [23:0]      word_sr;
  logic             accept;
  logic             last_byte;
  logic             last_word;
  logic             load_go;

  // Handshake decoded from state rather than in_ready to keep the FSM block acyclic
  assign accept    = in_valid && (state == ASSEMBLE);
  assign last_byte = accept && (byte_cnt == 2'd3);
  assign last_word = (words_done + CNT_W'(1)) == num_cap;
  assign load_go   = (state == IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    cpu_hold  = 1'b0;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_oe    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (num_words == '0) ? DONE_ST : ASSEMBLE;
      end
      ASSEMBLE: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (last_byte) state_nxt = WRITE;
      end
      WRITE: begin
        cpu_hold  = 1'b1;
        mem_cs    = 1'b1;
        mem_we    = 1'b1;
        state_nxt = last_word ? DONE_ST : ASSEMBLE;
      end
      DONE_ST: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_cap    <= '0;
      byte_cnt   <= 2'd0;
      word_sr    <= 24'd0;
      mem_addr   <= 32'd0;
      mem_din    <= 32'd0;
      done       <= 1'b0;
      words_done <= '0;
      checksum   <= 32'd0;
    end else begin
      if (load_go) begin
        num_cap    <= num_words;
        words_done <= '0;
        checksum   <= 32'd0;
        byte_cnt   <= 2'd0;
        done       <= (num_words == '0);
      end
      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        word_sr  <= {word_sr[15:0], in_byte};
      end
      // Address and data are latched with the 4th byte so they hold after WRITE
      if (last_byte) begin
        mem_din  <= {word_sr, in_byte};
        mem_addr <= BASE_ADDR + (32'(words_done) << 2);
      end
      if (state == WRITE) begin
        words_done <= words_done + CNT_W'(1);
        checksum   <= checksum + mem_din;
        byte_cnt   <= 2'd0;
        if (last_word) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (base 0 and a wrapping base) share stimulus
// and are checked against a byte-queue reference model.
module tb_imem_loader;
  localparam logic [31:0] BASE_A = 32'h0000_0000;
  localparam logic [31:0] BASE_B = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_words = 16'd0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = 8'd0;

  logic        in_ready_a, mem_cs_a, mem_oe_a, mem_we_a, cpu_hold_a, done_a;
  logic [31:0] mem_addr_a, mem_din_a, checksum_a;
  logic [15:0] words_done_a;
  logic        in_ready_b, mem_cs_b, mem_oe_b, mem_we_b, cpu_hold_b, done_b;
  logic [31:0] mem_addr_b, mem_din_b, checksum_b;
  logic [15:0] words_done_b;

  imem_loader #(.BASE_ADDR(BASE_A), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
    .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready_a),
    .mem_cs(mem_cs_a), .mem_oe(mem_oe_a), .mem_we(mem_we_a),
    .mem_addr(mem_addr_a), .mem_din(mem_din_a), .cpu_hold(cpu_hold_a),
    .done(done_a), .words_done(words_done_a), .checksum(checksum_a));

  imem_loader #(.BASE_ADDR(BASE_B), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
    .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready_b),
    .mem_cs(mem_cs_b), .mem_oe(mem_oe_b), .mem_we(mem_we_b),
    .mem_addr(mem_addr_b), .mem_din(mem_din_b), .cpu_hold(cpu_hold_b),
    .done(done_b), .words_done(words_done_b), .checksum(checksum_b));

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  logic [63:0] log_a[$];
  logic [63:0] log_b[$];
  logic [7:0]  byte_q[$];
  bit hold_seen = 1'b0;
  bit oe_seen   = 1'b0;
  bit cs_bad    = 1'b0;

  // SRAM write observer, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_we_a) log_a.push_back({mem_addr_a, mem_din_a});
    if (mem_we_b) log_b.push_back({mem_addr_b, mem_din_b});
    if (cpu_hold_a) hold_seen = 1'b1;
    if (mem_oe_a || mem_oe_b) oe_seen = 1'b1;
    if ((mem_we_a != mem_cs_a) || (mem_we_b != mem_cs_b)) cs_bad = 1'b1;
  end

  typedef struct {
    int          n;
    int          gap;
    logic [31:0] w[3];
    logic [31:0] exp_sum;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic feed(input int gap, input int mid_idx);
    int idx = 0;
    int budget = 2000;
    bit mid_done = 1'b0;
    while (idx < byte_q.size() && budget > 0) begin
      in_valid = gap != 0 ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_byte  = byte_q[idx];
      if (mid_idx >= 0 && idx == mid_idx && !mid_done) begin
        start = 1'b1;
        num_words = 16'd7;
        mid_done = 1'b1;
      end
      @(negedge clk);
      if (in_valid && in_ready_a) idx++;
      tick();
      start = 1'b0;
      budget--;
    end
    in_valid = 1'b0;
    if (budget == 0) chk("feed_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    int b = 0;
    while (!(done_a && !cpu_hold_a) && b < 50) begin
      tick();
      b++;
    end
    if (b == 50) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_dut(input int k, input int n);
    logic [31:0] base, sum, w;
    logic [63:0] e;
    int cnt;
    base = (k != 0) ? BASE_B : BASE_A;
    sum  = 32'd0;
    cnt  = (k != 0) ? log_b.size() : log_a.size();
    chk($sformatf("d%0d_nwrites", k), 32'(cnt), 32'(n));
    for (int i = 0; i < n; i++) begin
      w = {byte_q[4*i], byte_q[4*i+1], byte_q[4*i+2], byte_q[4*i+3]};
      sum = sum + w;
      if (i < cnt) begin
        e = (k != 0) ? log_b[i] : log_a[i];
        chk($sformatf("d%0d_addr%0d", k, i), e[63:32], base + 32'(4 * i));
        chk($sformatf("d%0d_data%0d", k, i), e[31:0], w);
      end
    end
    chk($sformatf("d%0d_words_done", k), {16'd0, (k != 0) ? words_done_b : words_done_a}, 32'(n));
    chk($sformatf("d%0d_checksum", k), (k != 0) ? checksum_b : checksum_a, sum);
    chk($sformatf("d%0d_done", k), {31'd0, (k != 0) ? done_b : done_a}, 32'd1);
    chk($sformatf("d%0d_cpu_hold", k), {31'd0, (k != 0) ? cpu_hold_b : cpu_hold_a}, 32'd0);
  endtask

  task automatic run_load(input int n, input int gap, input int mid_idx);
    log_a.delete();
    log_b.delete();
    start = 1'b1;
    num_words = 16'(n);
    tick();
    start = 1'b0;
    feed(gap, mid_idx);
    wait_done();
    check_dut(0, n);
    check_dut(1, n);
    tick();
  endtask

  task automatic fill_words(input int n, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2);
    logic [31:0] w;
    byte_q.delete();
    for (int i = 0; i < n; i++) begin
      w = (i == 0) ? w0 : (i == 1) ? w1 : w2;
      for (int j = 3; j >= 0; j--) byte_q.push_back(w[8*j +: 8]);
    end
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{n: 2, gap: 0, w: '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0}, exp_sum: 32'hACF1_3568};
    vecs[1] = '{n: 3, gap: 1, w: '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0BAD_F00D}, exp_sum: 32'hB89F_2575};
    vecs[2] = '{n: 1, gap: 1, w: '{32'hFFFF_FFFF, 32'h0, 32'h0}, exp_sum: 32'hFFFF_FFFF};
    vecs[3] = '{n: 2, gap: 0, w: '{32'hFFFF_FFFF, 32'h0000_0002, 32'h0}, exp_sum: 32'h0000_0001};

    #3;
    chk("rst_in_ready", {31'd0, in_ready_a}, 32'd0);
    chk("rst_cpu_hold", {31'd0, cpu_hold_a}, 32'd0);
    chk("rst_done", {31'd0, done_a}, 32'd0);
    chk("rst_addr", mem_addr_b, 32'd0);
    chk("rst_we", {31'd0, mem_we_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 4; v++) begin
      fill_words(vecs[v].n, vecs[v].w[0], vecs[v].w[1], vecs[v].w[2]);
      run_load(vecs[v].n, vecs[v].gap, -1);
      chk($sformatf("vec%0d_sum", v), checksum_a, vecs[v].exp_sum);
      chk($sformatf("vec%0d_sum_b", v), checksum_b, vecs[v].exp_sum);
    end

    // zero-length load
    log_a.delete();
    hold_seen = 1'b0;
    start = 1'b1;
    num_words = 16'd0;
    tick();
    start = 1'b0;
    tick();
    chk("zero_done", {31'd0, done_a}, 32'd1);
    chk("zero_words", {16'd0, words_done_a}, 32'd0);
    chk("zero_sum", checksum_a, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("zero_writes", 32'(log_a.size()), 32'd0);
    chk("zero_hold", {31'd0, hold_seen}, 32'd0);

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 5);
      byte_q.delete();
      for (int i = 0; i < 4 * n; i++) byte_q.push_back(8'($urandom));
      run_load(n, r % 2, -1);
    end

    // start mid-load must not re-sample num_words
    fill_words(2, 32'hCAFE_BABE, 32'h0102_0304, 32'h0);
    run_load(2, 0, 5);

    // async reset mid-word
    fill_words(3, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666);
    run_load(3, 0, -1);
    byte_q.delete();
    byte_q.push_back(8'hAA);
    byte_q.push_back(8'hBB);
    start = 1'b1;
    num_words = 16'd2;
    tick();
    start = 1'b0;
    feed(0, -1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", {31'd0, in_ready_a}, 32'd0);
    chk("arst_cpu_hold", {31'd0, cpu_hold_a}, 32'd0);
    chk("arst_done", {31'd0, done_a}, 32'd0);
    chk("arst_addr_a", mem_addr_a, 32'd0);
    chk("arst_din_a", mem_din_a, 32'd0);
    chk("arst_sum", checksum_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    fill_words(1, 32'h0102_0304, 32'h0, 32'h0);
    run_load(1, 0, -1);

    chk("oe_never", {31'd0, oe_seen}, 32'd0);
    chk("cs_eq_we", {31'd0, cs_bad}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
